ula_kb_debounce_bank: RTL and testbench

Parametrised keyboard-input front end that replaces the plain per-pin keyboard input pads with a bank of NUM_CH channels. Each channel has:
- a synchroniser on the raw pad level;
- a per-channel debounce counter, advanced only on a shared sample strobe.

It delivers clean, active-low key levels plus one-cycle change pulses to the port-read logic. It sits between the keyboard pad cells and the data-bus read mux.

---
 rtl/ula_kb_debounce_bank_if.sv | 41 ++++
 rtl/ula_kb_debounce_bank.sv | 141 ++++++++++++++
 tb/tb_ula_kb_debounce_bank.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/ula_kb_debounce_bank_if.sv
// Keyboard front-end bundle: raw pads and sample strobe in, debounced levels
// and change pulses out. With ULA_KB_IRQ_EN defined the bundle also carries
// the keyboard interrupt acknowledge and the active-low interrupt line.
interface ula_kb_debounce_bank_if #(
   parameter int NUM_CH = 5
);
   logic [NUM_CH-1:0] pad_in;
   logic              tick;
   logic [NUM_CH-1:0] kb_level;
   logic [NUM_CH-1:0] kb_fall;
   logic [NUM_CH-1:0] kb_rise;
   logic              any_key;
`ifdef ULA_KB_IRQ_EN
   logic              kb_int_ack;
   logic              n_kb_int;

   // Pad/port-read side
   modport master (
      output pad_in, tick, kb_int_ack,
      input  kb_level, kb_fall, kb_rise, any_key, n_kb_int
   );

   // Debounce bank side
   modport slave (
      input  pad_in, tick, kb_int_ack,
      output kb_level, kb_fall, kb_rise, any_key, n_kb_int
   );
`else
   // Pad/port-read side
   modport master (
      output pad_in, tick,
      input  kb_level, kb_fall, kb_rise, any_key
   );

   // Debounce bank side
   modport slave (
      input  pad_in, tick,
      output kb_level, kb_fall, kb_rise, any_key
   );
`endif
endinterface

// File: rtl/ula_kb_debounce_bank.sv
// ula_kb_debounce_bank: bank of NUM_CH keyboard input channels.
// Each channel synchronises its asynchronous pad level through SYNC_STAGES
// flops, then debounces it with its own counter that only advances on the
// shared sample strobe. A new level is accepted after DEB_COUNT consecutive
// strobes that disagree with the current level; acceptance produces a
// one-cycle fall (press) or rise (release) pulse aligned with the new level.
// Optional macro ULA_KB_IRQ_EN adds an active-low keyboard interrupt that is
// set by any press pulse and cleared by kb_int_ack (set has priority).
module ula_kb_debounce_bank #(
   parameter int NUM_CH      = 5,
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 4,
   parameter int DEB_COUNT   = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   ula_kb_debounce_bank_if.slave        kb
);

   // Terminal count: the strobe that finds the counter here accepts the level.
   localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_COUNT - 1);

   // Synchroniser chain, stage 0 samples the pads, the last stage feeds debounce.
   logic [SYNC_STAGES-1:0][NUM_CH-1:0] sync_q;
   logic [NUM_CH-1:0]                  samp;

   // Per-channel registered results gathered into bank-wide vectors.
   logic [NUM_CH-1:0] level_vec;
   logic [NUM_CH-1:0] fall_vec;
   logic [NUM_CH-1:0] rise_vec;
   logic              any_key_q;

   // Shift pads through the synchroniser every clock, independent of tick.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '1;
      end else begin
         sync_q[0] <= kb.pad_in;
         for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_q[k] <= sync_q[k-1];
         end
      end
   end

   assign samp = sync_q[SYNC_STAGES-1];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
         logic [CNT_W-1:0] cnt_q;
         logic [CNT_W-1:0] cnt_d;
         logic             level_q;
         logic             level_d;
         logic             fall_q;
         logic             fall_d;
         logic             rise_q;
         logic             rise_d;

         // Debounce decision: count disagreeing strobes, accept at terminal count.
         always_comb begin
            cnt_d   = cnt_q;
            level_d = level_q;
            fall_d  = 1'b0;
            rise_d  = 1'b0;
            if (kb.tick) begin
               if (samp[gi] == level_q) begin
                  // Any agreeing sample (e.g. a glitch back) restarts the count.
                  cnt_d = '0;
               end else if (cnt_q >= DEB_LAST) begin
                  level_d = samp[gi];
                  cnt_d   = '0;
                  fall_d  = ~samp[gi];
                  rise_d  = samp[gi];
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end

         // Channel state; reset drops partial counts without emitting pulses.
         always_ff @(posedge clk) begin
            if (rst) begin
               cnt_q   <= '0;
               level_q <= 1'b1;
               fall_q  <= 1'b0;
               rise_q  <= 1'b0;
            end else begin
               cnt_q   <= cnt_d;
               level_q <= level_d;
               fall_q  <= fall_d;
               rise_q  <= rise_d;
            end
         end

         assign level_vec[gi] = level_q;
         assign fall_vec[gi]  = fall_q;
         assign rise_vec[gi]  = rise_q;
      end
   endgenerate

   // Any-key flag follows the debounced levels one clock later.
   always_ff @(posedge clk) begin
      if (rst) begin
         any_key_q <= 1'b0;
      end else begin
         any_key_q <= ~(&level_vec);
      end
   end

   assign kb.kb_level = level_vec;
   assign kb.kb_fall  = fall_vec;
   assign kb.kb_rise  = rise_vec;
   assign kb.any_key  = any_key_q;

`ifdef ULA_KB_IRQ_EN
   logic n_kb_int_q;
   logic n_kb_int_d;

   // Interrupt request: any press sets it (low), ack clears it, set wins.
   always_comb begin
      n_kb_int_d = n_kb_int_q;
      if (|fall_vec) begin
         n_kb_int_d = 1'b0;
      end else if (kb.kb_int_ack) begin
         n_kb_int_d = 1'b1;
      end
   end

   // Interrupt line register, inactive (high) out of reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         n_kb_int_q <= 1'b1;
      end else begin
         n_kb_int_q <= n_kb_int_d;
      end
   end

   assign kb.n_kb_int = n_kb_int_q;
`endif

endmodule

// File: tb/tb_ula_kb_debounce_bank.sv
// Directed testbench for ula_kb_debounce_bank with default parameters.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_ula_kb_debounce_bank;

   logic clk;
   logic rst;
   int   n_tests;
   int   n_fail;
   logic [4:0] fall_acc;
   logic [4:0] rise_acc;

   ula_kb_debounce_bank_if #(.NUM_CH(5)) kb_bus ();

   ula_kb_debounce_bank #(
      .NUM_CH      (5),
      .SYNC_STAGES (2),
      .CNT_W       (4),
      .DEB_COUNT   (8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .kb  (kb_bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end else begin
         $display("[TB] ok %s = %0h", tag, got);
      end
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst = 1'b1;
      kb_bus.pad_in = 5'b00000;
      kb_bus.tick   = 1'b1;
`ifdef ULA_KB_IRQ_EN
      kb_bus.kb_int_ack = 1'b0;
`endif

      // 1. Reset with pads low
      step(3);
      chk("rst_level", 32'(kb_bus.kb_level), 32'h1f);
      chk("rst_fall",  32'(kb_bus.kb_fall),  32'h0);
      chk("rst_rise",  32'(kb_bus.kb_rise),  32'h0);
      chk("rst_any",   32'(kb_bus.any_key),  32'h0);
`ifdef ULA_KB_IRQ_EN
      chk("rst_nint",  32'(kb_bus.n_kb_int), 32'h1);
`endif
      rst = 1'b0;
      kb_bus.pad_in = 5'b11111;
      step(1);
      chk("post_rst_pulse", 32'({kb_bus.kb_fall, kb_bus.kb_rise}), 32'h0);

      // 2. Clean press on ch2: level changes 10 clocks after the pad
      kb_bus.pad_in = 5'b11011;
      step(9);
      chk("press2_c9_level", 32'(kb_bus.kb_level), 32'h1f);
      step(1);
      chk("press2_c10_level", 32'(kb_bus.kb_level), 32'h1b);
      chk("press2_c10_fall",  32'(kb_bus.kb_fall),  32'h04);
      chk("press2_c10_any",   32'(kb_bus.any_key),  32'h0);
      step(1);
      chk("press2_c11_fall",  32'(kb_bus.kb_fall),  32'h0);
      chk("press2_c11_any",   32'(kb_bus.any_key),  32'h1);
      kb_bus.pad_in = 5'b11111;
      step(10);
      chk("rel2_level", 32'(kb_bus.kb_level), 32'h1f);
      chk("rel2_rise",  32'(kb_bus.kb_rise),  32'h04);
      step(1);
      chk("rel2_rise_off", 32'(kb_bus.kb_rise), 32'h0);
      chk("rel2_any",      32'(kb_bus.any_key), 32'h0);

      // 3. Glitch rejection on ch0: 7 low, 1 high, 7 low
      fall_acc = '0;
      for (int i = 0; i < 21; i++) begin
         if (i < 7 || (i >= 8 && i < 15)) kb_bus.pad_in = 5'b11110;
         else kb_bus.pad_in = 5'b11111;
         step(1);
         fall_acc = fall_acc | kb_bus.kb_fall;
      end
      chk("glitch_level", 32'(kb_bus.kb_level), 32'h1f);
      chk("glitch_fall",  32'(fall_acc),        32'h0);

      // 4. Strobe every 4th clock, ch1 held low: accept on the 8th strobe (clock 32)
      kb_bus.pad_in = 5'b11101;
      for (int c = 1; c <= 32; c++) begin
         kb_bus.tick = (c % 4 == 0);
         step(1);
         if (c == 31) chk("gate_c31_level", 32'(kb_bus.kb_level), 32'h1f);
         if (c == 32) begin
            chk("gate_c32_level", 32'(kb_bus.kb_level), 32'h1d);
            chk("gate_c32_fall",  32'(kb_bus.kb_fall),  32'h02);
         end
      end
      kb_bus.tick = 1'b1;
      kb_bus.pad_in = 5'b11111;
      step(12);
      chk("gate_release_level", 32'(kb_bus.kb_level), 32'h1f);

      // 5. Simultaneous press and release of ch4/ch3
      kb_bus.pad_in = 5'b00111;
      step(10);
      chk("sim_press_level", 32'(kb_bus.kb_level), 32'h07);
      chk("sim_press_fall",  32'(kb_bus.kb_fall),  32'h18);
      step(1);
      kb_bus.pad_in = 5'b11111;
      step(10);
      chk("sim_rel_level", 32'(kb_bus.kb_level), 32'h1f);
      chk("sim_rel_rise",  32'(kb_bus.kb_rise),  32'h18);
      step(1);

      // 5b. Reset at strobe 5 of a release: no pulses, levels all released
      kb_bus.pad_in = 5'b00111;
      step(11);
      chk("pre_rst_level", 32'(kb_bus.kb_level), 32'h07);
      kb_bus.pad_in = 5'b11111;
      step(6);
      rst = 1'b1;
      step(1);
      chk("mid_rst_level", 32'(kb_bus.kb_level), 32'h1f);
      chk("mid_rst_pulse", 32'({kb_bus.kb_fall, kb_bus.kb_rise}), 32'h0);
      chk("mid_rst_any",   32'(kb_bus.any_key), 32'h0);
      rst = 1'b0;
      fall_acc = '0;
      rise_acc = '0;
      for (int i = 0; i < 12; i++) begin
         step(1);
         fall_acc = fall_acc | kb_bus.kb_fall;
         rise_acc = rise_acc | kb_bus.kb_rise;
      end
      chk("after_rst_pulses", 32'({fall_acc, rise_acc}), 32'h0);
      chk("after_rst_level",  32'(kb_bus.kb_level), 32'h1f);

`ifdef ULA_KB_IRQ_EN
      // 6. Interrupt: set on press, set beats coincident ack, lone ack clears
      chk("irq_idle", 32'(kb_bus.n_kb_int), 32'h1);
      kb_bus.pad_in = 5'b11110;
      step(10);
      chk("irq_fall0",     32'(kb_bus.kb_fall),  32'h01);
      chk("irq_not_yet",   32'(kb_bus.n_kb_int), 32'h1);
      step(1);
      chk("irq_set",       32'(kb_bus.n_kb_int), 32'h0);
      kb_bus.pad_in = 5'b11100;
      step(10);
      chk("irq_fall1",     32'(kb_bus.kb_fall),  32'h02);
      kb_bus.kb_int_ack = 1'b1;
      step(1);
      kb_bus.kb_int_ack = 1'b0;
      chk("irq_set_wins",  32'(kb_bus.n_kb_int), 32'h0);
      step(2);
      chk("irq_hold",      32'(kb_bus.n_kb_int), 32'h0);
      kb_bus.kb_int_ack = 1'b1;
      step(1);
      kb_bus.kb_int_ack = 1'b0;
      chk("irq_ack_clear", 32'(kb_bus.n_kb_int), 32'h1);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
